// File: rtl/t5_lsu_pkg.sv
// Shared t5 definitions: access-size codes, opcode constants, LSU FSM states and the byte-lane helper.
package t5_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Byte-lane mask for an access of 2^size bytes starting at byte offset ofs (up to 8 lanes).
    function automatic logic [7:0] lane_sel(input logic [1:0] size, input logic [2:0] ofs);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            SZ_D:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << ofs;
    endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Data alignment for the LSU: load lane extract with sign/zero extension, store data lane replication.
module t5_lsu_align
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              dti_i,
    input  logic [$clog2(XLEN/8)-1:0]    ofs_i,
    input  logic [1:0]                   ld_size_i,
    input  logic                         uns_i,
    input  logic [XLEN-1:0]              xdat_i,
    input  logic [1:0]                   st_size_i,
    output logic [XLEN-1:0]              ld_dat_o,
    output logic [XLEN-1:0]              st_dat_o
);

    logic [XLEN-1:0] sh_s;
    logic [XLEN-1:0] msk_s;
    logic            msb_s;

    // Right-align the addressed field, then keep its bytes and fill the rest with the extension bit.
    always_comb begin
        sh_s = dti_i >> {ofs_i, 3'b000};
        case (ld_size_i)
            SZ_B: begin
                msk_s = XLEN'(8'hFF);
                msb_s = sh_s[7];
            end
            SZ_H: begin
                msk_s = XLEN'(16'hFFFF);
                msb_s = sh_s[15];
            end
            SZ_W: begin
                msk_s = XLEN'(32'hFFFF_FFFF);
                msb_s = sh_s[31];
            end
            default: begin
                msk_s = {XLEN{1'b1}};
                msb_s = sh_s[XLEN-1];
            end
        endcase
        ld_dat_o = (sh_s & msk_s) | (~msk_s & {XLEN{~uns_i & msb_s}});
    end

    // Replicate the right-aligned store field so every candidate lane carries it.
    always_comb begin
        case (st_size_i)
            SZ_B:    st_dat_o = {(XLEN/8){xdat_i[7:0]}};
            SZ_H:    st_dat_o = {(XLEN/16){xdat_i[15:0]}};
            SZ_W:    st_dat_o = {(XLEN/32){xdat_i[31:0]}};
            default: st_dat_o = xdat_i;
        endcase
    end

endmodule

// File: rtl/t5_lsu.sv
// t5 load/store unit: effective address, Wishbone data-port sequencing, misalign and timeout reporting.
module t5_lsu
    import t5_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TMO  = 255
) (
    input  logic                              sclk,
    input  logic                              srst,
    input  logic                              sena,
    input  logic [6:2]                        dopc,
    input  logic [14:12]                      dfn3,
    input  logic [XLEN-1:0]                   xbas,
    input  logic [XLEN-1:0]                   xoff,
    input  logic [XLEN-1:0]                   xdat,
    output logic [XLEN-$clog2(XLEN/8)-1:0]    dwb_adr,
    output logic [XLEN-1:0]                   dwb_dto,
    output logic [XLEN/8-1:0]                 dwb_sel,
    output logic                              dwb_stb,
    output logic                              dwb_wre,
    input  logic [XLEN-1:0]                   dwb_dti,
    input  logic                              dwb_ack,
    output logic                              lsu_busy,
    output logic                              lsu_vld,
    output logic [XLEN-1:0]                   lsu_dat,
    output logic                              lsu_mis,
    output logic                              lsu_err
);

    localparam int AB = $clog2(XLEN/8);
    localparam int SW = XLEN/8;
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TMO);

    lsu_state_e        state_q, state_d;
    logic [XLEN-AB-1:0] adr_q, adr_d;
    logic [XLEN-1:0]   dto_q, dto_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              wre_q, wre_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic [XLEN-1:0]   dat_q, dat_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [AB-1:0]     ofs_q, ofs_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN-1:0]   ea_s;
    logic [AB-1:0]     ofs_s;
    logic [1:0]        size_s;
    logic              is_ld_s;
    logic              is_st_s;
    logic              align_ok_s;
    logic [XLEN-1:0]   ld_dat_s;
    logic [XLEN-1:0]   st_dat_s;

    t5_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .dti_i     (dwb_dti),
        .ofs_i     (ofs_q),
        .ld_size_i (size_q),
        .uns_i     (uns_q),
        .xdat_i    (xdat),
        .st_size_i (size_s),
        .ld_dat_o  (ld_dat_s),
        .st_dat_o  (st_dat_s)
    );

    // Decode the incoming request: effective address, size and natural-alignment legality.
    always_comb begin
        ea_s    = xbas + xoff;
        ofs_s   = ea_s[AB-1:0];
        size_s  = dfn3[13:12];
        is_ld_s = (dopc == OP_LOAD);
        is_st_s = (dopc == OP_STORE);
        case (size_s)
            SZ_B:    align_ok_s = 1'b1;
            SZ_H:    align_ok_s = ~ofs_s[0];
            SZ_W:    align_ok_s = (ofs_s[1:0] == 2'b00);
            SZ_D:    align_ok_s = (XLEN == 64) && (ofs_s == {AB{1'b0}});
            default: align_ok_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; pulses default low, bus registers hold unless updated.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dto_d   = dto_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        wre_d   = wre_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        dat_d   = dat_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        size_d  = size_q;
        uns_d   = uns_q;
        ofs_d   = ofs_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sena && (is_ld_s || is_st_s)) begin
                    if (align_ok_s) begin
                        adr_d   = ea_s[XLEN-1:AB];
                        sel_d   = SW'(lane_sel(size_s, 3'(ofs_s)));
                        dto_d   = st_dat_s;
                        stb_d   = 1'b1;
                        wre_d   = is_st_s;
                        busy_d  = 1'b1;
                        size_d  = size_s;
                        uns_d   = dfn3[14];
                        ofs_d   = ofs_s;
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_BUS;
                    end else begin
                        mis_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (dwb_ack) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    busy_d  = 1'b0;
                    vld_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!wre_q) begin
                        dat_d = ld_dat_s;
                    end else begin
                        dat_d = dat_q;
                    end
                end else if ((TMO != 0) && (cnt_q == TMO_LAST)) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q != TMO_MAX) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
                wre_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle, quiet bus.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            adr_q   <= {(XLEN-AB){1'b0}};
            dto_q   <= {XLEN{1'b0}};
            sel_q   <= {SW{1'b0}};
            stb_q   <= 1'b0;
            wre_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            dat_q   <= {XLEN{1'b0}};
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            ofs_q   <= {AB{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dto_q   <= dto_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            wre_q   <= wre_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            ofs_q   <= ofs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dwb_adr  = adr_q;
    assign dwb_dto  = dto_q;
    assign dwb_sel  = sel_q;
    assign dwb_stb  = stb_q;
    assign dwb_wre  = wre_q;
    assign lsu_busy = busy_q;
    assign lsu_vld  = vld_q;
    assign lsu_dat  = dat_q;
    assign lsu_mis  = mis_q;
    assign lsu_err  = err_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Directed bench for t5_lsu: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_t5_lsu;

    logic sclk;
    int   checks;
    int   errors;

    // 32-bit instance, TMO=3
    logic        a_srst, a_sena, a_ack;
    logic [6:2]  a_dopc;
    logic [14:12] a_dfn3;
    logic [31:0] a_xbas, a_xoff, a_xdat, a_dti;
    logic [29:0] a_adr;
    logic [31:0] a_dto, a_dat;
    logic [3:0]  a_sel;
    logic        a_stb, a_wre, a_busy, a_vld, a_mis, a_err;

    // 64-bit instance, default timeout
    logic        b_srst, b_sena, b_ack;
    logic [6:2]  b_dopc;
    logic [14:12] b_dfn3;
    logic [63:0] b_xbas, b_xoff, b_xdat, b_dti;
    logic [60:0] b_adr;
    logic [63:0] b_dto, b_dat;
    logic [7:0]  b_sel;
    logic        b_stb, b_wre, b_busy, b_vld, b_mis, b_err;

    t5_lsu #(.XLEN(32), .TMO(3)) u_a (
        .sclk(sclk), .srst(a_srst), .sena(a_sena), .dopc(a_dopc), .dfn3(a_dfn3),
        .xbas(a_xbas), .xoff(a_xoff), .xdat(a_xdat),
        .dwb_adr(a_adr), .dwb_dto(a_dto), .dwb_sel(a_sel), .dwb_stb(a_stb), .dwb_wre(a_wre),
        .dwb_dti(a_dti), .dwb_ack(a_ack),
        .lsu_busy(a_busy), .lsu_vld(a_vld), .lsu_dat(a_dat), .lsu_mis(a_mis), .lsu_err(a_err)
    );

    t5_lsu #(.XLEN(64), .TMO(255)) u_b (
        .sclk(sclk), .srst(b_srst), .sena(b_sena), .dopc(b_dopc), .dfn3(b_dfn3),
        .xbas(b_xbas), .xoff(b_xoff), .xdat(b_xdat),
        .dwb_adr(b_adr), .dwb_dto(b_dto), .dwb_sel(b_sel), .dwb_stb(b_stb), .dwb_wre(b_wre),
        .dwb_dti(b_dti), .dwb_ack(b_ack),
        .lsu_busy(b_busy), .lsu_vld(b_vld), .lsu_dat(b_dat), .lsu_mis(b_mis), .lsu_err(b_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_srst = 1'b1; a_sena = 1'b0; a_ack = 1'b0; a_dopc = 5'b11111; a_dfn3 = 3'b000;
        a_xbas = 32'h0; a_xoff = 32'h0; a_xdat = 32'h0; a_dti = 32'h0;
        b_srst = 1'b1; b_sena = 1'b0; b_ack = 1'b0; b_dopc = 5'b11111; b_dfn3 = 3'b000;
        b_xbas = 64'h0; b_xoff = 64'h0; b_xdat = 64'h0; b_dti = 64'h0;
        tick();
        tick();
        a_srst = 1'b0;
        b_srst = 1'b0;
        chk("rst_stb", {63'h0, a_stb}, 64'h0);
        chk("rst_busy", {63'h0, a_busy}, 64'h0);
        chk("rst_vld_mis_err_wre", {60'h0, a_vld, a_mis, a_err, a_wre}, 64'h0);
        chk("rst_adr", {34'h0, a_adr}, 64'h0);
        chk("rst_sel_dto_dat", {28'h0, a_sel, a_dto | a_dat}, 64'h0);
        chk("rst64_sel_stb", {55'h0, b_sel, b_stb}, 64'h0);

        // LB at ea 0x1003, ack in first bus cycle
        a_dopc = 5'b00000; a_dfn3 = 3'b000; a_xbas = 32'h0000_1003; a_xoff = 32'h0; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("lb_stb", {63'h0, a_stb}, 64'h1);
        chk("lb_sel", {60'h0, a_sel}, 64'h8);
        chk("lb_adr", {34'h0, a_adr}, 64'h400);
        chk("lb_wre_busy", {62'h0, a_wre, a_busy}, 64'h1);
        a_dti = 32'h8012_3456; a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("lb_vld", {63'h0, a_vld}, 64'h1);
        chk("lb_dat", {32'h0, a_dat}, 64'hFFFF_FF80);
        chk("lb_done_stb_busy", {62'h0, a_stb, a_busy}, 64'h0);
        tick();
        chk("lb_vld_pulse", {63'h0, a_vld}, 64'h0);

        // SH at ea 0x2002
        a_dopc = 5'b01000; a_dfn3 = 3'b001; a_xbas = 32'h0000_2000; a_xoff = 32'h2;
        a_xdat = 32'h0000_ABCD; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("sh_sel", {60'h0, a_sel}, 64'hC);
        chk("sh_dto", {32'h0, a_dto}, 64'hABCD_ABCD);
        chk("sh_wre_stb", {62'h0, a_wre, a_stb}, 64'h3);
        chk("sh_adr", {34'h0, a_adr}, 64'h800);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("sh_vld", {63'h0, a_vld}, 64'h1);
        chk("sh_dat_kept", {32'h0, a_dat}, 64'hFFFF_FF80);
        chk("sh_wre_off", {63'h0, a_wre}, 64'h0);
        tick();

        // LW misaligned at 0x1002
        a_dopc = 5'b00000; a_dfn3 = 3'b010; a_xbas = 32'h0000_1000; a_xoff = 32'h2; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("lw_mis", {63'h0, a_mis}, 64'h1);
        chk("lw_mis_stb_busy", {62'h0, a_stb, a_busy}, 64'h0);
        tick();
        chk("lw_mis_pulse", {62'h0, a_mis, a_stb}, 64'h0);

        // LD on 32-bit is always illegal
        a_dfn3 = 3'b011; a_xbas = 32'h0; a_xoff = 32'h0; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("ld32_mis", {62'h0, a_mis, a_stb}, 64'h2);
        tick();

        // LHU with negative offset: ea 0x3000-2 = 0x2FFE
        a_dfn3 = 3'b101; a_xbas = 32'h0000_3000; a_xoff = 32'hFFFF_FFFE; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("lhu_sel", {60'h0, a_sel}, 64'hC);
        chk("lhu_adr", {34'h0, a_adr}, 64'hBFF);
        a_dti = 32'h8765_1234; a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("lhu_dat", {32'h0, a_dat}, 64'h0000_8765);
        tick();

        // ack while idle is ignored
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("idle_ack", {62'h0, a_vld, a_busy}, 64'h0);

        // Timeout with TMO=3: three strobe cycles, then err
        a_dfn3 = 3'b010; a_xbas = 32'h0000_0100; a_xoff = 32'h0; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("tmo_stb1", {63'h0, a_stb}, 64'h1);
        tick();
        chk("tmo_stb2", {63'h0, a_stb}, 64'h1);
        tick();
        chk("tmo_stb3", {62'h0, a_stb, a_err}, 64'h2);
        tick();
        chk("tmo_err", {61'h0, a_stb, a_err, a_vld}, 64'h2);
        chk("tmo_busy", {63'h0, a_busy}, 64'h0);
        tick();
        chk("tmo_err_pulse", {62'h0, a_err, a_vld}, 64'h0);
        a_dfn3 = 3'b000; a_xbas = 32'h0000_0101; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("tmo_next_stb", {63'h0, a_stb}, 64'h1);
        a_dti = 32'h0000_7F00; a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("tmo_next_vld", {63'h0, a_vld}, 64'h1);
        chk("tmo_next_dat", {32'h0, a_dat}, 64'h0000_007F);
        tick();

        // srst in BUS, then late ack
        a_dfn3 = 3'b010; a_xbas = 32'h0000_0200; a_sena = 1'b1;
        tick();
        a_sena = 1'b0;
        chk("rst_bus_stb", {63'h0, a_stb}, 64'h1);
        a_srst = 1'b1;
        tick();
        a_srst = 1'b0;
        chk("rst_bus_drop", {62'h0, a_stb, a_busy}, 64'h0);
        chk("rst_bus_dat", {32'h0, a_dat}, 64'h0);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("rst_late_ack", {62'h0, a_vld, a_stb}, 64'h0);
        tick();
        chk("rst_late_ack2", {63'h0, a_vld}, 64'h0);

        // 64-bit LD at 0x8, ack withheld 4 cycles
        b_dopc = 5'b00000; b_dfn3 = 3'b011; b_xbas = 64'h8; b_xoff = 64'h0; b_sena = 1'b1;
        tick();
        b_sena = 1'b0;
        chk("ld64_stb", {63'h0, b_stb}, 64'h1);
        chk("ld64_sel", {56'h0, b_sel}, 64'hFF);
        chk("ld64_adr", {3'h0, b_adr}, 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ld64_hold", {54'h0, b_stb, b_sel, b_adr[0]}, 64'h3FF);
        end
        b_dti = 64'h8000_0000_1234_5678; b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("ld64_vld", {62'h0, b_vld, b_stb}, 64'h2);
        chk("ld64_dat", b_dat, 64'h8000_0000_1234_5678);
        tick();

        // 64-bit LB signed at ofs 5
        b_dfn3 = 3'b000; b_xbas = 64'h10; b_xoff = 64'h5; b_sena = 1'b1;
        tick();
        b_sena = 1'b0;
        chk("lb64_sel", {56'h0, b_sel}, 64'h20);
        chk("lb64_adr", {3'h0, b_adr}, 64'h2);
        b_dti = 64'h0000_7F00_0000_0000; b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("lb64_dat", b_dat, 64'h7F);
        tick();

        // 64-bit SW at ofs 4
        b_dopc = 5'b01000; b_dfn3 = 3'b010; b_xbas = 64'h20; b_xoff = 64'h4;
        b_xdat = 64'h1111_2222_DEAD_BEEF; b_sena = 1'b1;
        tick();
        b_sena = 1'b0;
        chk("sw64_sel", {56'h0, b_sel}, 64'hF0);
        chk("sw64_dto", b_dto, 64'hDEAD_BEEF_DEAD_BEEF);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("sw64_vld", {63'h0, b_vld}, 64'h1);
        tick();

        // 64-bit LW signed at ofs 4
        b_dopc = 5'b00000; b_dfn3 = 3'b010; b_xbas = 64'h30; b_xoff = 64'h4; b_sena = 1'b1;
        tick();
        b_sena = 1'b0;
        b_dti = 64'h8000_0001_0000_0000; b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("lw64_dat", b_dat, 64'hFFFF_FFFF_8000_0001);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
